lfsr_rr_server: RTL and testbench

- Shared pseudo-random byte server.
- One internal 8-bit Galois LFSR is time-shared between NREQ requesters by a round-robin arbiter.
- Each grant delivers one LFSR word, and the LFSR advances exactly once per word served, so no two requesters ever receive the same sample.
- Sits between test/stimulus engines (traffic generators, scramblers, BIST) and the LFSR datapath. It also owns seeding and freeze control.

---
 rtl/lfsr_rr_server.sv | 89 ++++++++
 tb/tb_lfsr_rr_server.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/lfsr_rr_server.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lfsr_rr_server                                               |
// | Description : 8-bit Galois LFSR shared round-robin among NREQ requesters.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lfsr_rr_server #(
  parameter int        NREQ       = 4,
  parameter logic [7:0] RESET_SEED = 8'h0F
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [7:0]      rdata,
  input  logic            seed_load,
  input  logic [7:0]      seed,
  output logic [15:0]     served,
  output logic [7:0]      lfsr_state
);

  localparam int              PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0]   c_last = PW'(NREQ - 1);
  localparam logic [PW:0]     c_nreq = (PW + 1)'(NREQ);

  logic [7:0]      r_lfsr;
  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] r_gnt;
  logic [7:0]      r_rdata;
  logic [15:0]     r_served;

  logic [7:0]      w_step;
  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_ptr_nxt;
  logic [NREQ-1:0] w_gnt_nxt;

  assign w_step = {r_lfsr[6:4], r_lfsr[7] ^ r_lfsr[3], r_lfsr[7] ^ r_lfsr[2],
                   r_lfsr[7] ^ r_lfsr[1], r_lfsr[0], r_lfsr[7]};

  // Scan from the pointer upward, wrapping; the first set request wins.
  always_comb begin : p_arb
    logic [PW:0] v_idx;
    v_idx     = '0;
    w_found   = 1'b0;
    w_win     = '0;
    w_gnt_nxt = '0;
    for (int i = 0; i < NREQ; i++) begin
      v_idx = {1'b0, r_ptr} + (PW + 1)'(i);
      if (v_idx >= c_nreq) v_idx = v_idx - c_nreq;
      if (!w_found && req[v_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = v_idx[PW-1:0];
      end
    end
    if (w_found) w_gnt_nxt[w_win] = 1'b1;
    w_ptr_nxt = (w_win == c_last) ? '0 : w_win + PW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr   <= RESET_SEED;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_rdata  <= 8'h00;
      r_served <= 16'h0000;
    end else begin
      r_gnt <= '0;
      // Seeding wins over everything, and zero would lock the LFSR up.
      if (seed_load) begin
        r_lfsr <= (seed == 8'h00) ? RESET_SEED : seed;
      end else if (enable && w_found) begin
        r_gnt    <= w_gnt_nxt;
        r_rdata  <= r_lfsr;
        r_lfsr   <= w_step;
        r_ptr    <= w_ptr_nxt;
        r_served <= r_served + 16'd1;
      end
    end
  end

  assign gnt        = r_gnt;
  assign rdata      = r_rdata;
  assign served     = r_served;
  assign lfsr_state = r_lfsr;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_rr_server.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lfsr_rr_server                                            |
// | Description : Directed self-checking bench for lfsr_rr_server.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lfsr_rr_server;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [7:0]  rdata;
  logic        seed_load;
  logic [7:0]  seed;
  logic [15:0] served;
  logic [7:0]  lfsr_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_seq [8] = '{8'h0F, 8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hFD, 8'hE7, 8'hD3};
  logic [3:0] exp_rr  [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b0001, 4'b0010, 4'b0100, 4'b1000};

  lfsr_rr_server #(.NREQ(4), .RESET_SEED(8'h0F)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .req        (req),
    .gnt        (gnt),
    .rdata      (rdata),
    .seed_load  (seed_load),
    .seed       (seed),
    .served     (served),
    .lfsr_state (lfsr_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs are examined 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    chk("rst_gnt", 16'(gnt), 16'h0);
    chk("rst_rdata", 16'(rdata), 16'h00);
    chk("rst_served", served, 16'h0);
    chk("rst_lfsr", 16'(lfsr_state), 16'h0F);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; req = 4'b0000; seed_load = 1'b0; seed = 8'h00;
    #1;
    chk("async_rst_gnt", 16'(gnt), 16'h0);
    do_reset();

    // Single requester: consecutive grants with the LFSR sequence.
    req = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t1_gnt%0d", k), 16'(gnt), 16'b0001);
      chk($sformatf("t1_rdata%0d", k), 16'(rdata), 16'(exp_seq[k]));
    end
    req = 4'b0000;
    tick();
    chk("t1_idle_gnt", 16'(gnt), 16'h0);
    chk("t1_hold_rdata", 16'(rdata), 16'hF0);
    chk("t1_served", served, 16'd5);
    chk("t1_lfsr", 16'(lfsr_state), 16'hFD);

    // All requesting: strict rotation.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("t2_gnt%0d", k), 16'(gnt), 16'(exp_rr[k]));
      chk($sformatf("t2_rdata%0d", k), 16'(rdata), 16'(exp_seq[k]));
    end
    chk("t2_served", served, 16'd8);
    chk("t2_lfsr", 16'(lfsr_state), 16'hBB);
    req = 4'b0000;
    tick();

    // Pointer wrap: after granting 2, search starts at 3 and wraps to 0.
    do_reset();
    req = 4'b0100;
    tick();
    chk("t3_gnt_a", 16'(gnt), 16'b0100);
    chk("t3_rdata_a", 16'(rdata), 16'h0F);
    req = 4'b0101;
    tick();
    chk("t3_gnt_b", 16'(gnt), 16'b0001);
    chk("t3_rdata_b", 16'(rdata), 16'h1E);
    tick();
    chk("t3_gnt_c", 16'(gnt), 16'b0100);
    chk("t3_rdata_c", 16'(rdata), 16'h3C);

    // Seeding: zero substitutes the reset seed; seeded cycle yields no grant.
    req = 4'b0010; seed_load = 1'b1; seed = 8'h00;
    tick();
    chk("t4_gnt_seed0", 16'(gnt), 16'h0);
    chk("t4_lfsr_seed0", 16'(lfsr_state), 16'h0F);
    seed_load = 1'b0;
    tick();
    chk("t4_gnt_a", 16'(gnt), 16'b0010);
    chk("t4_rdata_a", 16'(rdata), 16'h0F);
    seed_load = 1'b1; seed = 8'hA5;
    tick();
    chk("t4_gnt_seedA5", 16'(gnt), 16'h0);
    chk("t4_lfsr_seedA5", 16'(lfsr_state), 16'hA5);
    seed_load = 1'b0;
    tick();
    chk("t4_gnt_b", 16'(gnt), 16'b0010);
    chk("t4_rdata_b", 16'(rdata), 16'hA5);
    req = 4'b0000;
    tick();
    chk("t4_served", served, 16'd5);

    // Freeze: nothing moves while enable is low.
    enable = 1'b0; req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t5_gnt%0d", k), 16'(gnt), 16'h0);
      chk($sformatf("t5_lfsr%0d", k), 16'(lfsr_state), 16'h57);
      chk($sformatf("t5_served%0d", k), served, 16'd5);
    end
    enable = 1'b1;
    tick();
    chk("t5_gnt_resume", 16'(gnt), 16'b0100);
    chk("t5_rdata_resume", 16'(rdata), 16'h57);

    // Asynchronous reset while a grant is showing.
    tick();
    chk("t6_gnt_pre", 16'(gnt), 16'b1000);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_gnt_async", 16'(gnt), 16'h0);
    chk("t6_served_async", served, 16'h0);
    chk("t6_lfsr_async", 16'(lfsr_state), 16'h0F);
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6_gnt_post", 16'(gnt), 16'b0001);
    chk("t6_rdata_post", 16'(rdata), 16'h0F);
    chk("t6_served_post", served, 16'd1);
    req = 4'b0000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
